// File: rtl/rr_arb_mux_pkg.sv
// Shared types and helpers for the round-robin arbitrated multiplexer.
package rr_arb_mux_pkg;

    // Width of a channel index: at least one bit even for a single channel.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Packet lock state (only used when RR_ARB_MUX_LOCK_EN is defined).
    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

endpackage

// File: rtl/rr_arb_mux_if.sv
// Handshake bundle for rr_arb_mux: NCH request channels in, one stream out.
// slave : the multiplexer's view; master : the producer/consumer environment.
interface rr_arb_mux_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4
) ();
    localparam int SELW = rr_arb_mux_pkg::sel_width(NCH);

    logic [NCH-1:0]   in_valid;
    logic [NCH-1:0]   in_ready;
    logic [WIDTH-1:0] in_data [NCH-1:0];
    logic [NCH-1:0]   in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [SELW-1:0]  out_sel;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/rr_arb_mux_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins,
// wrapping modulo NCH. No state; the pointer is owned by the caller.
module rr_arbiter
    import rr_arb_mux_pkg::*;
#(
    parameter  int NCH  = 4,
    localparam int SELW = sel_width(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    input  logic            en,
    output logic [NCH-1:0]  grant,
    output logic [SELW-1:0] grant_idx
);

    generate
        if (NCH == 1) begin : g_single
            logic unused_single_s;
            assign unused_single_s = ^{req, ptr};

            // Single channel: the grant is simply the enable.
            always_comb begin
                grant     = en;
                grant_idx = '0;
            end
        end else begin : g_multi
            logic            found_s;
            logic [SELW-1:0] idx_s;

            // Rotating search starting at ptr; first requester found takes the grant.
            always_comb begin
                grant     = '0;
                grant_idx = '0;
                found_s   = 1'b0;
                idx_s     = '0;
                for (int k = 0; k < NCH; k++) begin
                    idx_s = SELW'((int'(ptr) + k) % NCH);
                    if (en && !found_s && req[idx_s]) begin
                        grant[idx_s] = 1'b1;
                        grant_idx    = idx_s;
                        found_s      = 1'b1;
                    end else begin
                        found_s = found_s;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel round-robin arbitrated mux with a one-entry registered output stage.
// Optional packet lock enabled by defining RR_ARB_MUX_LOCK_EN.
module rr_arb_mux
    import rr_arb_mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NCH   = 4
) (
    input  logic         clk,
    input  logic         reset,
    rr_arb_mux_if.slave  bus
);
    localparam int SELW = sel_width(NCH);

    logic             load_ok_s;
    logic             arb_en_s;
    logic [NCH-1:0]   req_s;
    logic [SELW-1:0]  ptr_arb_s;
    logic [NCH-1:0]   grant_s;
    logic [SELW-1:0]  grant_idx_s;
    logic             xfer_s;
    logic             ptr_adv_s;
    logic [SELW-1:0]  ptr_nx_s;
    logic [WIDTH-1:0] sel_data_s;

    logic [SELW-1:0]  ptr_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic [SELW-1:0]  out_sel_r;

    // Stage can accept when empty or draining this cycle; no grants during reset.
    assign load_ok_s = ~out_valid_r | bus.out_ready;
    assign arb_en_s  = load_ok_s & reset;
    assign xfer_s    = |(grant_s & bus.in_valid);
    assign ptr_nx_s  = (grant_idx_s == SELW'(NCH - 1)) ? '0 : grant_idx_s + SELW'(1);

    rr_arbiter #(.NCH(NCH)) u_arb (
        .req       (req_s),
        .ptr       (ptr_arb_s),
        .en        (arb_en_s),
        .grant     (grant_s),
        .grant_idx (grant_idx_s)
    );

`ifdef RR_ARB_MUX_LOCK_EN
    lock_state_e      lock_state_r;
    lock_state_e      lock_state_nx_s;
    logic [SELW-1:0]  lock_ch_r;
    logic [SELW-1:0]  lock_ch_nx_s;
    logic [NCH-1:0]   lock_mask_s;

    // While locked only the owning channel may request, and it is searched first.
    always_comb begin
        lock_mask_s            = '0;
        lock_mask_s[lock_ch_r] = 1'b1;
        if (lock_state_r == LOCKED) begin
            req_s     = bus.in_valid & lock_mask_s;
            ptr_arb_s = lock_ch_r;
        end else begin
            req_s     = bus.in_valid;
            ptr_arb_s = ptr_r;
        end
    end

    // Lock next-state: a non-last beat locks onto its channel, a last beat releases.
    always_comb begin
        lock_state_nx_s = lock_state_r;
        lock_ch_nx_s    = lock_ch_r;
        ptr_adv_s       = 1'b0;
        if (xfer_s) begin
            case (bus.in_last[grant_idx_s])
                1'b0: begin
                    lock_state_nx_s = LOCKED;
                    lock_ch_nx_s    = grant_idx_s;
                end
                1'b1: begin
                    lock_state_nx_s = UNLOCKED;
                    ptr_adv_s       = 1'b1;
                end
                default: begin
                    lock_state_nx_s = UNLOCKED;
                    ptr_adv_s       = 1'b1;
                end
            endcase
        end else begin
            ptr_adv_s = 1'b0;
        end
    end

    // Lock state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_state_r <= UNLOCKED;
            lock_ch_r    <= '0;
        end else begin
            lock_state_r <= lock_state_nx_s;
            lock_ch_r    <= lock_ch_nx_s;
        end
    end
`else
    logic unused_last_s;
    assign unused_last_s = ^bus.in_last;

    // Plain round robin: every beat re-arbitrates, every transfer advances ptr.
    always_comb begin
        req_s     = bus.in_valid;
        ptr_arb_s = ptr_r;
        ptr_adv_s = xfer_s;
    end
`endif

    // AND-OR data select: unselected channels are masked to zero, so X cannot leak.
    always_comb begin
        sel_data_s = '0;
        for (int i = 0; i < NCH; i++) begin
            sel_data_s = sel_data_s | (bus.in_data[i] & {WIDTH{grant_s[i]}});
        end
    end

    // Output stage and priority pointer: load on transfer, empty on drain, else hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_sel_r   <= '0;
            ptr_r       <= '0;
        end else begin
            if (xfer_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= sel_data_s;
                out_sel_r   <= grant_idx_s;
            end else if (bus.out_ready) begin
                out_valid_r <= 1'b0;
            end
            if (ptr_adv_s) begin
                ptr_r <= ptr_nx_s;
            end
        end
    end

    assign bus.in_ready  = grant_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_sel   = out_sel_r;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed self-checking bench for rr_arb_mux (NCH=4, WIDTH=8).
// Expected grant order for the packet test depends on RR_ARB_MUX_LOCK_EN.
module tb_rr_arb_mux;
    localparam int WIDTH = 8;
    localparam int NCH   = 4;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    rr_arb_mux_if #(.WIDTH(WIDTH), .NCH(NCH)) bus ();

    rr_arb_mux #(.WIDTH(WIDTH), .NCH(NCH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one active edge and settle past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [WIDTH-1:0] base);
        for (int i = 0; i < NCH; i++) begin
            bus.in_data[i] = base + WIDTH'(i);
        end
    endtask

    int exp_sel [5];

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        reset         = 1'b1;
        bus.in_valid  = 4'b1111;
        bus.in_last   = 4'b1111;
        bus.out_ready = 1'b1;
        set_data(8'hA0);

        // 1. asynchronous reset with all channels requesting
        #2 reset = 1'b0;
        #1;
        check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_val("rst_out_data",  32'(bus.out_data),  32'd0);
        check_val("rst_out_sel",   32'(bus.out_sel),   32'd0);
        check_val("rst_in_ready",  32'(bus.in_ready),  32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_val("rel_in_ready", 32'(bus.in_ready), 32'h1);

        // 2. all valid, out_ready high: 0,1,2,3,0 back to back
        for (int k = 0; k < 5; k++) begin
            step();
            check_val("rr_valid", 32'(bus.out_valid), 32'd1);
            check_val("rr_sel",   32'(bus.out_sel),   32'(k % 4));
            check_val("rr_data",  32'(bus.out_data),  32'(8'hA0 + (k % 4)));
        end
        check_val("rr_ptr_ready", 32'(bus.in_ready), 32'h2);

        // drain: no valid, out_ready high -> empty
        bus.in_valid = 4'b0000;
        step();
        check_val("drain_valid", 32'(bus.out_valid), 32'd0);

        // 3. backpressure: single beat from ch2 held while out_ready low
        bus.in_data[2] = 8'h5C;
        bus.in_valid   = 4'b0100;
        bus.out_ready  = 1'b0;
        step();
        bus.in_data[2] = 8'h77;
        for (int k = 0; k < 5; k++) begin
            #1;
            check_val("bp_valid", 32'(bus.out_valid), 32'd1);
            check_val("bp_data",  32'(bus.out_data),  32'h5C);
            check_val("bp_ready", 32'(bus.in_ready),  32'h0);
            step();
        end
        check_val("bp_sel", 32'(bus.out_sel), 32'd2);
        bus.out_ready = 1'b1;
        #1;
        check_val("bp_release_ready", 32'(bus.in_ready), 32'h4);
        step();
        check_val("bp_reload_valid", 32'(bus.out_valid), 32'd1);
        check_val("bp_reload_data",  32'(bus.out_data),  32'h77);

        // 4. wrap: ptr=3, only ch0 and ch3 valid -> ch3 then ch0
        bus.in_data[0] = 8'h10;
        bus.in_data[3] = 8'h13;
        bus.in_valid   = 4'b1001;
        step();
        check_val("wrap_sel0",  32'(bus.out_sel),  32'd3);
        check_val("wrap_data0", 32'(bus.out_data), 32'h13);
        step();
        check_val("wrap_sel1",  32'(bus.out_sel),  32'd0);
        check_val("wrap_data1", 32'(bus.out_data), 32'h10);

        // 5. reset while holding a beat; after release ptr restarts at 0
        bus.in_data[1] = 8'h21;
        bus.in_valid   = 4'b1010;
        reset          = 1'b0;
        #1;
        check_val("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check_val("mid_rst_ready", 32'(bus.in_ready),  32'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_val("post_rst_ready", 32'(bus.in_ready), 32'h2);
        step();
        check_val("post_rst_sel",  32'(bus.out_sel),  32'd1);
        check_val("post_rst_data", 32'(bus.out_data), 32'h21);

        // 6. packet from ch1 with ch0/ch2 competing; first bring ptr to 1
        bus.in_valid = 4'b0000;
        step();
        bus.in_valid = 4'b0001;
        step();
        check_val("pk_setup_sel", 32'(bus.out_sel), 32'd0);
`ifdef RR_ARB_MUX_LOCK_EN
        exp_sel = '{1, 1, 1, 2, 0};
`else
        exp_sel = '{1, 2, 0, 1, 2};
`endif
        set_data(8'hB0);
        bus.in_valid = 4'b0111;
        for (int k = 0; k < 5; k++) begin
            bus.in_last = (k == 2) ? 4'b0111 : 4'b0101;
            step();
            check_val("pk_sel",  32'(bus.out_sel),  32'(exp_sel[k]));
            check_val("pk_data", 32'(bus.out_data), 32'(8'hB0 + exp_sel[k]));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
